// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: register map, edge-mode encodings and a clog2 helper shared by the
// GPIO input block and its per-bit synchroniser.
package gpio_in_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpio_in_sync_debounce.sv
// gpio_in_sync_debounce: one input bit through a SYNC_STAGES flop synchroniser, followed
// by a stable-count debouncer when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_sync_debounce
    import gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic out_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4)
        $error("SYNC_STAGES out of range");
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535)
        $error("DEBOUNCE_CYCLES out of range");

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // The counter only runs while the synchronised input disagrees with the held value
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_out != db_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            db_d  = (cnt_q == CNT_LAST) ? sync_out : db_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign out_o = db_q;
`else
    assign out_o = sync_out;
`endif

endmodule

// File: rtl/gpio_in_edge_capture.sv
// gpio_in_edge_capture: Avalon-MM GPIO input port with synchronisers, sticky edge capture,
// irq mask and level irq. Define GPIO_IN_DEBOUNCE_EN to add a per-bit debouncer.
module gpio_in_edge_capture
    import gpio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32)
        $error("WIDTH out of range");
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY)
        $error("EDGE_TYPE out of range");

    // Edge detection stays off until the synchroniser (and debouncer) hold real samples
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int WARMUP = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int WARMUP = SYNC_STAGES + 1;
`endif
    localparam int WW = clog2(WARMUP + 1);
    localparam logic [WW-1:0] WARM_DONE = WW'(WARMUP);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [WIDTH-1:0] edge_rise, edge_fall, edge_any, edges, clr;
    logic             wr, warm;

    for (genvar i = 0; i < WIDTH; i++) begin : g_in
        gpio_in_sync_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[i]),
            .out_o  (data[i])
        );
    end

    assign edge_rise = data & ~prev_q;
    assign edge_fall = ~data & prev_q;
    assign edge_any  = data ^ prev_q;
    assign edges     = (EDGE_TYPE == EDGE_RISE) ? edge_rise :
                       (EDGE_TYPE == EDGE_FALL) ? edge_fall : edge_any;

    assign wr   = chipselect & ~write_n;
    assign warm = (warm_q == WARM_DONE);
    assign clr  = (wr && address == ADDR_EDGECAP) ? writedata : '0;

    // New edges are OR-ed in after the clear so a coincident event is never lost
    always_comb begin
        warm_d     = warm ? warm_q : warm_q + WW'(1);
        edgecap_d  = (edgecap_q & ~clr) | (warm ? edges : '0);
        irqmask_d  = (wr && address == ADDR_IRQMASK) ? writedata : irqmask_q;
        readdata_d = (address == ADDR_DATA)    ? data      :
                     (address == ADDR_RSVD)    ? '0        :
                     (address == ADDR_IRQMASK) ? irqmask_q : edgecap_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            warm_q     <= '0;
        end else begin
            prev_q     <= data;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            warm_q     <= warm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: doc/gpio_in_edge_capture.md
Name: gpio_in_edge_capture

Overview:
Parametrised Avalon-MM slave for general-purpose input ports. It is the successor to the fixed 2-bit, data-only input PIO.
- Adds configurable width, input synchronisation, per-bit edge capture, an interrupt mask register and a level interrupt output.
- Sits on the Nios system interconnect and samples board-level inputs such as clocks, switches and card-detect lines.

Parameters:
WIDTH, 8, number of input bits (1..32).
SYNC_STAGES, 2, synchroniser flop depth per bit (2..4).
EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
DEBOUNCE_CYCLES, 16, stable-cycle count; used only with GPIO_IN_DEBOUNCE_EN (2..65535).

Ports:
clk  input  1  system clock.
reset_n  input  1  reset, asynchronous assert, active-low.
address  input  2  word address within the slave.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe.
writedata  input  WIDTH  write data.
readdata  output  WIDTH  registered read data.
in_port  input  WIDTH  asynchronous external inputs.
irq  output  1  level interrupt to the CPU.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. On reset the following all clear to 0: readdata, the synchroniser chain, the previous-value register, irqmask, edgecapture and the warm-up counter. irq is therefore 0.
- Register map:
  - 0 = data (RO): synchronised input value.
  - 1 = reserved: reads 0, writes ignored.
  - 2 = irqmask (RW).
  - 3 = edgecapture (RO, write-1-to-clear).
- Read: readdata is loaded every clk with the mux output for the current address, giving 1-cycle read latency. chipselect is not required for a read, and reads have no side effects.
- Write: a write takes effect when chipselect=1 and write_n=0.
  - Address 2 loads irqmask.
  - Address 3 clears every edgecapture bit whose writedata bit is 1.
- Synchroniser: each in_port bit passes through SYNC_STAGES flops. sync_out is the last stage; prev is sync_out delayed by one cycle.
- Edge detect:
  - Rising edge: sync_out & ~prev.
  - Falling edge: ~sync_out & prev.
  - Any edge: XOR of the two.
- Latency: an in_port change is visible in data after SYNC_STAGES cycles. The edgecapture bit and irq assert SYNC_STAGES+1 cycles after the change.
- Warm-up: after reset release, a counter runs for SYNC_STAGES+1 cycles. Edge detection is suppressed until it saturates, so inputs already high at reset produce no spurious capture. The counter holds at its terminal value afterwards.
- edgecapture bits are sticky until cleared by software.
- Simultaneous clear and new edge on the same bit: set wins, so the event is not lost.
- irq = |(edgecapture & irqmask), combinational from registers. No output glitch occurs on the register side.
- Partial-width writedata: bits above WIDTH do not exist. The bus wrapper zero-extends.
- Reset asserted mid-operation returns all state to reset values immediately, and the warm-up restarts on release.

Optional Feature:
GPIO_IN_DEBOUNCE_EN
- Defined: a per-bit debouncer sits between sync_out and the data/edge logic. The debounced bit updates only after sync_out differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the current value resets that bit's counter. Data and edge latency grow by DEBOUNCE_CYCLES. Counter width is clog2(DEBOUNCE_CYCLES+1), and counters reset to 0.
- Undefined: no debouncer is present and the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package gpio_in_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2;
  - a clog2 function.
- Sub-module gpio_in_sync_debounce: a single-bit synchroniser plus optional debouncer, instantiated WIDTH times in a generate loop.
- The top level holds the edge, register and irq logic.

Test Plan:
1. Reset with in_port=8'hFF held; release → after 10 cycles, edgecapture=0 and irq=0; read addr 0 → 8'hFF.
2. Set in_port bit3 0→1 at cycle 0 (rising mode, SYNC_STAGES=2) → data bit3 reads 1 from cycle 2; edgecapture=8'h08 at cycle 3. irq=0 while irqmask=0, and irq=1 the cycle after writing irqmask=8'h08.
3. With edgecapture=8'h08, write 8'h08 to addr 3 on the same cycle a new bit3 rising edge is detected → edgecapture stays 8'h08 and irq stays 1. A later write of 8'h08 clears it to 0.
4. EDGE_TYPE=2: pulse bit0 1→0→1 with 5-cycle spacing, clearing between pulses → each transition sets edgecapture bit0.
5. Read addr 1 after writing 8'hAA to it → readdata=0 and irqmask unchanged.
6. With GPIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: 10-cycle glitch on bit5 → no data change and no capture. A 20-cycle high level → data bit5=1 after 2+16 cycles, and the capture follows one cycle later.
